// File: rtl/sync_ram_ctrl_if.sv
// sync_ram_ctrl_if: request/response valid-ready bundle between a requester and sync_ram_ctrl
interface sync_ram_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: credit-gated front-end for a 1-cycle-latency sync RAM with response FIFO; RAM_CLEAR_EN adds a post-reset zeroing sweep
module sync_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_ram_ctrl_if.slave        bus,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int OW = PW + 1;
  logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [OW-1:0]         occ;
  logic                  rd_pending, run, clearing, accept, push, pop;
  logic [ADDR_WIDTH-1:0] clr_addr;
`ifdef RAM_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;
  // state register and sweep counter; any reset restarts the sweep at address 0
  always_ff @(posedge clk)
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
    end
  // leave CLEAR once the last address has been written
  always_comb begin
    state_nxt = (state == CLEAR && &clr_addr) ? RUN : state;
  end
  assign run      = !rst && state == RUN;
  assign clearing = !rst && state == CLEAR;
`else
  assign run      = !rst;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif
  // a credit is every read still owed to the consumer: queued or in flight
  assign bus.req_ready = run && (({1'b0, occ} + (OW+1)'(rd_pending)) < (OW+1)'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign busy          = clearing;
  assign ram_we        = clearing || (accept && bus.req_we);
  assign ram_addr      = clearing ? clr_addr : bus.req_addr;
  assign ram_din       = clearing ? '0 : bus.req_wdata;
  assign bus.rsp_valid = !rst && occ != '0;
  assign bus.rsp_rdata = fifo[rd_ptr];
  assign push          = !rst && rd_pending;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  // occupancy, pointers and the in-flight read flag
  always_ff @(posedge clk)
    if (rst) begin
      occ        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= accept && !bus.req_we;
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      occ        <= occ + OW'(push) - OW'(pop);
    end
  // capture the RAM's registered read data; storage is deliberately not reset
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= ram_dout;
endmodule

// File: tb/tb_sync_ram_ctrl.sv
// tb_sync_ram_ctrl: table vectors, directed corner sequences and random traffic checked against a queue-based model
module tb_sync_ram_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RD = 4;
  localparam int NA = 16;
`ifdef RAM_CLEAR_EN
  localparam int CLR = NA;
`else
  localparam int CLR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [DW-1:0] ram [NA];

  sync_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  sync_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  typedef struct {
    bit            v;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            e_rdy;
    bit            e_vld;
    logic [DW-1:0] e_data;
  } vec_t;

  rsp_t          q[$];
  logic [DW-1:0] ref_mem [NA];
  int            cyc, clear_left, vectors, miscompares;
  bit            last_acc, o_rdy, o_vld;
  logic [DW-1:0] o_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input bit r, input bit v, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit rr,
                      output bit rdy, output bit vld, output logic [DW-1:0] data);
    bit e_rdy, e_vld, e_busy, ovf;
    rst = r;
    bus.req_valid = v;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    @(negedge clk);
    e_busy = !r && clear_left > 0;
    e_rdy  = !r && !e_busy && q.size() < RD;
    e_vld  = !r && q.size() > 0 && q[0].due <= cyc;
    rdy = bus.req_ready;
    vld = bus.rsp_valid;
    data = bus.rsp_rdata;
    chk("req_ready", rdy, e_rdy);
    chk("rsp_valid", vld, e_vld);
    chk("busy", busy, e_busy);
    if (e_vld) chk("rsp_rdata", data, q[0].d);
    chk("ram_we", ram_we, e_busy || (v && e_rdy && we));
    if (e_busy) begin
      chk("clear_addr", ram_addr, NA - clear_left);
      chk("clear_din", ram_din, 0);
    end else if (v && e_rdy) begin
      chk("ram_addr", ram_addr, a);
      if (we) chk("ram_din", ram_din, d);
    end
    ovf = dut.rd_pending && dut.occ == RD && !(bus.rsp_valid && bus.rsp_ready);
    chk("fifo_overflow", ovf, 0);
    last_acc = v && e_rdy;
    if (r) begin
      q.delete();
      clear_left = CLR;
    end else begin
      if (e_busy) begin
        ref_mem[NA - clear_left] = '0;
        clear_left--;
      end
      if (e_vld && rr) void'(q.pop_front());
      if (last_acc) begin
        if (we) ref_mem[a] = d;
        else q.push_back('{d: ref_mem[a], due: cyc + 2});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) tick(0, 0, 0, '0, '0, rr, o_rdy, o_vld, o_data);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, '0, '0, 1, o_rdy, o_vld, o_data);
    while (clear_left > 0) idle(1, 1);
  endtask

  initial begin
    vec_t tbl[6];
    bit v, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int n;
    tbl[0] = '{v: 1, we: 1, a: 3, d: 8'hA5, e_rdy: 1, e_vld: 0, e_data: 8'h00};
    tbl[1] = '{v: 1, we: 0, a: 3, d: 8'h00, e_rdy: 1, e_vld: 0, e_data: 8'h00};
    tbl[2] = '{v: 0, we: 0, a: 0, d: 8'h00, e_rdy: 1, e_vld: 0, e_data: 8'h00};
    tbl[3] = '{v: 0, we: 0, a: 0, d: 8'h00, e_rdy: 1, e_vld: 1, e_data: 8'hA5};
    tbl[4] = '{v: 0, we: 0, a: 0, d: 8'h00, e_rdy: 1, e_vld: 0, e_data: 8'h00};
    tbl[5] = '{v: 1, we: 0, a: 3, d: 8'h00, e_rdy: 1, e_vld: 0, e_data: 8'h00};
    cyc = 0;
    clear_left = 0;
    vectors = 0;
    miscompares = 0;
    last_acc = 0;
    rst = 1;
    bus.req_valid = 0;
    bus.req_we = 0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1;
    do_reset(2);
    for (int i = 0; i < NA; i++) tick(0, 1, 1, AW'(i), DW'($urandom), 1, o_rdy, o_vld, o_data);
    for (int i = 0; i < 6; i++) begin
      tick(0, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, 1, o_rdy, o_vld, o_data);
      chk("tbl_ready", o_rdy, tbl[i].e_rdy);
      chk("tbl_valid", o_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) chk("tbl_rdata", o_data, tbl[i].e_data);
    end
    idle(3, 1);
    for (int i = 0; i < 8; i++) tick(0, 1, 1, AW'(i), DW'(8'h10 + i), 1, o_rdy, o_vld, o_data);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 0, AW'(i), '0, 1, o_rdy, o_vld, o_data);
      chk("b2b_ready", o_rdy, 1);
      n += int'(o_vld);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1, 1);
      n += int'(o_vld);
    end
    chk("b2b_count", n, 8);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      tick(0, 1, 0, AW'(i), '0, 0, o_rdy, o_vld, o_data);
      n += int'(o_rdy);
    end
    chk("credit_accepts", n, RD);
    idle(6, 1);
    idle(1, 1);
    chk("credit_return", o_rdy, 1);
    for (int i = 4; i < 8; i++) tick(0, 1, 0, AW'(i), '0, 0, o_rdy, o_vld, o_data);
    do_reset(1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1, 1);
      n += int'(o_vld);
    end
    chk("no_stale_rsp", n, 0);
    tick(0, 1, 0, 5, '0, 1, o_rdy, o_vld, o_data);
    idle(3, 1);
    v = 0;
    we = 0;
    a = '0;
    d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!(v && !last_acc)) begin
        v = $urandom_range(0, 3) != 0;
        we = $urandom_range(0, 1) == 1;
        a = AW'($urandom);
        d = DW'($urandom);
      end
      tick(0, v, we, a, d, $urandom_range(0, 2) != 0, o_rdy, o_vld, o_data);
    end
    idle(8, 1);
`ifdef RAM_CLEAR_EN
    do_reset(1);
    idle(7, 1);
    do_reset(1);
    for (int i = 0; i < NA; i++) tick(0, 1, 0, AW'(i), '0, 1, o_rdy, o_vld, o_data);
    idle(3, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
